multiplier: RTL and testbench

- Unsigned iterative shift-and-add multiplier with a registered product output.
- Continuously monitors its two operand inputs. When they differ from the last captured pair, it recomputes the full-width product over DATA_WIDTH clock cycles.
- Used as a self-triggering arithmetic leaf: the consumer drives operands, waits, then samples outputValue, or qualifies it with o_valid.

---
 rtl/multiplier_if.sv | 24 ++
 rtl/multiplier.sv | 147 ++++++++++++++
 tb/tb_multiplier.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/multiplier_if.sv
// Operand/result bundle for the iterative multiplier.
// The master drives the operands and observes the product; the slave is the multiplier.
interface multiplier_if #(
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]   input1;
    logic [DATA_WIDTH-1:0]   input2;
    logic [2*DATA_WIDTH-1:0] outputValue;
    logic                    o_valid;

    modport master (
        output input1,
        output input2,
        input  outputValue,
        input  o_valid
    );

    modport slave (
        input  input1,
        input  input2,
        output outputValue,
        output o_valid
    );
endinterface

// File: rtl/multiplier.sv
// Self-triggering unsigned shift-and-add multiplier.
// Whenever the operand pair differs from the last captured pair (or right after
// reset), a new DATA_WIDTH-cycle computation starts. The product register only
// changes on completion, so intermediate sums never reach the output.
module multiplier #(
    parameter int DATA_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    multiplier_if.slave   mul_bus
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d;
    logic [DATA_WIDTH-1:0] op2_q, op2_d;
    logic [PW-1:0]         mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  first_q, first_d;
    logic [PW-1:0]         product_q, product_d;
    logic                  valid_q, valid_d;

    logic                  launch_s;
    logic                  last_step_s;
    logic [PW-1:0]         step_sum_s;

    // A new operand pair (or the first cycle after reset) triggers a computation.
    assign launch_s    = first_q ||
                         ({mul_bus.input1, mul_bus.input2} != {op1_q, op2_q});
    assign last_step_s = (cnt_q == CNT_LAST);
    // One partial product per cycle: add the shifted multiplicand when the current multiplier bit is set.
    assign step_sum_s  = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: launch from IDLE, return after the final step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_s) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_step_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values for the current state.
    always_comb begin
        op1_d     = op1_q;
        op2_d     = op2_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        product_d = product_q;
        valid_d   = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_s) begin
                    op1_d    = mul_bus.input1;
                    op2_d    = mul_bus.input2;
                    mcand_d  = {{DATA_WIDTH{1'b0}}, mul_bus.input1};
                    mplier_d = mul_bus.input2;
                    acc_d    = {PW{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    valid_d  = 1'b0;
                    first_d  = 1'b0;
                end else begin
                    valid_d  = valid_q;
                end
            end
            ST_BUSY: begin
                acc_d    = step_sum_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_step_s) begin
                    product_d = step_sum_s;
                    valid_d   = 1'b1;
                end else begin
                    product_d = product_q;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset clears everything and arms the first-launch flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op1_q     <= {DATA_WIDTH{1'b0}};
            op2_q     <= {DATA_WIDTH{1'b0}};
            mcand_q   <= {PW{1'b0}};
            mplier_q  <= {DATA_WIDTH{1'b0}};
            acc_q     <= {PW{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            first_q   <= 1'b1;
            product_q <= {PW{1'b0}};
            valid_q   <= 1'b0;
        end else begin
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            product_q <= product_d;
            valid_q   <= valid_d;
        end
    end

    assign mul_bus.outputValue = product_q;
    assign mul_bus.o_valid     = valid_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the iterative multiplier with a cycle-level behavioural model.
module tb_multiplier;

    localparam int DW = 4;
    localparam int PW = 2 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in1 = '0;
    logic [DW-1:0] in2 = '0;

    int n_vec = 0;
    int n_err = 0;

    multiplier_if #(.DATA_WIDTH(DW)) mul_bus ();

    assign mul_bus.input1 = in1;
    assign mul_bus.input2 = in2;

    multiplier #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .mul_bus (mul_bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: a computation takes DW edges after launch, then shows cap1*cap2.
    int            m_rem   = 0;
    bit            m_first = 1'b1;
    logic [DW-1:0] m_cap1  = '0;
    logic [DW-1:0] m_cap2  = '0;
    logic [PW-1:0] m_out   = '0;
    bit            m_valid = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem   = 0;
            m_first = 1'b1;
            m_cap1  = '0;
            m_cap2  = '0;
            m_out   = '0;
            m_valid = 1'b0;
        end else if (m_rem == 0) begin
            if (m_first || in1 != m_cap1 || in2 != m_cap2) begin
                m_first = 1'b0;
                m_cap1  = in1;
                m_cap2  = in2;
                m_rem   = DW;
                m_valid = 1'b0;
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_out   = PW'(int'(m_cap1) * int'(m_cap2));
                m_valid = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_out", int'(mul_bus.outputValue), int'(m_out));
            chk("model_valid", int'(mul_bus.o_valid), int'(m_valid));
        end
    end

    task automatic drive(input int a, input int b);
        @(negedge clk);
        in1 = DW'(a);
        in2 = DW'(b);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with zero operands, then release.
        wait_cycles(3);
        chk("reset_out", int'(mul_bus.outputValue), 0);
        chk("reset_valid", int'(mul_bus.o_valid), 0);
        rst = 1'b0;
        wait_cycles(4);
        chk("zero_not_yet_valid", int'(mul_bus.o_valid), 0);
        wait_cycles(1);
        chk("zero_valid", int'(mul_bus.o_valid), 1);
        chk("zero_out", int'(mul_bus.outputValue), 0);

        // 15*15: valid drops on launch, result four edges later.
        drive(15, 15);
        wait_cycles(1);
        chk("max_launch_valid", int'(mul_bus.o_valid), 0);
        chk("max_hold_old", int'(mul_bus.outputValue), 0);
        wait_cycles(4);
        chk("max_out", int'(mul_bus.outputValue), 225);
        chk("max_valid", int'(mul_bus.o_valid), 1);
        for (int k = 0; k < 10; k++) begin
            wait_cycles(1);
            chk("max_stable", int'(mul_bus.outputValue), 225);
        end

        // Operand change two cycles into a computation.
        drive(3, 6);
        wait_cycles(3);
        in1 = 4'd5;
        wait_cycles(2);
        chk("busy_change_first", int'(mul_bus.outputValue), 18);
        chk("busy_change_first_valid", int'(mul_bus.o_valid), 1);
        wait_cycles(1);
        chk("busy_change_relaunch_valid", int'(mul_bus.o_valid), 0);
        chk("busy_change_relaunch_hold", int'(mul_bus.outputValue), 18);
        wait_cycles(4);
        chk("busy_change_final", int'(mul_bus.outputValue), 30);
        chk("busy_change_final_valid", int'(mul_bus.o_valid), 1);

        // Asynchronous reset in the middle of a computation.
        drive(10, 11);
        wait_cycles(2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out", int'(mul_bus.outputValue), 0);
        chk("async_rst_valid", int'(mul_bus.o_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(5);
        chk("after_rst_out", int'(mul_bus.outputValue), 110);
        chk("after_rst_valid", int'(mul_bus.o_valid), 1);

        // Long hold: no retriggering.
        drive(8, 8);
        wait_cycles(5);
        for (int k = 0; k < 50; k++) begin
            chk("hold_out", int'(mul_bus.outputValue), 64);
            chk("hold_valid", int'(mul_bus.o_valid), 1);
            wait_cycles(1);
        end

        // Exhaustive sweep, each pair held ten cycles.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                drive(i, j);
                wait_cycles(9);
                chk("sweep_valid", int'(mul_bus.o_valid), 1);
                chk("sweep_out", int'(mul_bus.outputValue), i * j);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
